// File: rtl/hazard_ctrl.sv
// Hazard controller: tracks in-flight register writers in E/M/W and derives the decode stall and forwarding selects.
// Define HAZARD_W_BYPASS_EN to let the W slot act as a forwarding source (code 3); otherwise the GRF must write-through.
module hazard_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] grf_read_addr0,
    input  logic [4:0] grf_read_addr1,
    input  logic [1:0] grf_read_stage0,
    input  logic [1:0] grf_read_stage1,
    input  logic [4:0] grf_write_addr,
    input  logic [1:0] grf_write_stage,
    input  logic       ext_stall,
    output logic       stall,
    output logic [1:0] fwd_d0,
    output logic [1:0] fwd_d1,
    output logic [1:0] fwd_e0,
    output logic [1:0] fwd_e1,
    output logic [1:0] fwd_m1
);

    localparam logic [1:0] STAGE_DECODE = 2'd0;
    localparam logic [1:0] STAGE_MAX    = 2'd3;

    localparam logic [1:0] FWD_GRF = 2'd0;
    localparam logic [1:0] FWD_W   = 2'd3;

    typedef struct packed {
        logic [4:0] write_addr;
        logic [1:0] write_stage;
        logic [4:0] read_addr0;
        logic [4:0] read_addr1;
        logic [1:0] read_stage0;
        logic [1:0] read_stage1;
    } slot_t;

    typedef struct packed {
        logic       found;
        logic [1:0] pos;
        logic [1:0] write_stage;
    } match_t;

    localparam slot_t BUBBLE = '{
        write_addr:  5'd0,
        write_stage: STAGE_DECODE,
        read_addr0:  5'd0,
        read_addr1:  5'd0,
        read_stage0: STAGE_MAX,
        read_stage1: STAGE_MAX
    };

    slot_t  slot_d;
    slot_t  slot_e;
    slot_t  slot_m;
    slot_t  slot_w;

    match_t match_d0;
    match_t match_d1;
    match_t match_e0;
    match_t match_e1;

    logic   hazard_stall;
    logic   unused_slot_bits;

    // Youngest producer wins: search E (when the consumer is younger than E), then M, then W.
    function automatic match_t find_producer(input logic [4:0] r, input logic search_e,
                                             input slot_t e, input slot_t m, input slot_t w);
        match_t res;
        res = '0;
        if (r != 5'd0) begin
            if (search_e && e.write_addr == r) begin
                res = '{found: 1'b1, pos: 2'd1, write_stage: e.write_stage};
            end else if (m.write_addr == r) begin
                res = '{found: 1'b1, pos: 2'd2, write_stage: m.write_stage};
            end else if (w.write_addr == r) begin
                res = '{found: 1'b1, pos: 2'd3, write_stage: w.write_stage};
            end
        end
        return res;
    endfunction

    function automatic logic operand_stalls(input match_t mt, input logic [1:0] tuse);
        logic [2:0] need_at;
        need_at = {1'b0, mt.pos} + {1'b0, tuse};
        return mt.found && (tuse != STAGE_MAX) && (need_at <= {1'b0, mt.write_stage});
    endfunction

    // A producer that has not yet computed its value falls back to the GRF (the stall covers it).
    function automatic logic [1:0] fwd_code(input match_t mt);
        logic [1:0] code;
        code = FWD_GRF;
        if (mt.found && (mt.pos > mt.write_stage)) begin
            code = mt.pos;
        end
`ifndef HAZARD_W_BYPASS_EN
        if (code == FWD_W) begin
            code = FWD_GRF;
        end
`endif
        return code;
    endfunction

    assign slot_d = '{
        write_addr:  grf_write_addr,
        write_stage: grf_write_stage,
        read_addr0:  grf_read_addr0,
        read_addr1:  grf_read_addr1,
        read_stage0: grf_read_stage0,
        read_stage1: grf_read_stage1
    };

    assign match_d0 = find_producer(grf_read_addr0, 1'b1, slot_e, slot_m, slot_w);
    assign match_d1 = find_producer(grf_read_addr1, 1'b1, slot_e, slot_m, slot_w);
    assign match_e0 = find_producer(slot_e.read_addr0, 1'b0, slot_e, slot_m, slot_w);
    assign match_e1 = find_producer(slot_e.read_addr1, 1'b0, slot_e, slot_m, slot_w);

    assign hazard_stall = operand_stalls(match_d0, grf_read_stage0)
                        | operand_stalls(match_d1, grf_read_stage1);

    // Read-stage fields ride along in E/M/W for pipeline visibility but only the D copy matters here.
    assign unused_slot_bits = ^{slot_e, slot_m, slot_w};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_e <= BUBBLE;
            slot_m <= BUBBLE;
            slot_w <= BUBBLE;
        end else begin
            slot_w <= slot_m;
            slot_m <= slot_e;
            slot_e <= stall ? BUBBLE : slot_d;
        end
    end

    always_comb begin
        stall  = ext_stall;
        fwd_d0 = FWD_GRF;
        fwd_d1 = FWD_GRF;
        fwd_e0 = FWD_GRF;
        fwd_e1 = FWD_GRF;
        fwd_m1 = FWD_GRF;
        if (rst_n) begin
            stall  = ext_stall | hazard_stall;
            fwd_d0 = fwd_code(match_d0);
            fwd_d1 = fwd_code(match_d1);
            fwd_e0 = fwd_code(match_e0);
            fwd_e1 = fwd_code(match_e1);
`ifdef HAZARD_W_BYPASS_EN
            if (slot_m.read_addr1 != 5'd0 && slot_w.write_addr == slot_m.read_addr1) begin
                fwd_m1 = FWD_W;
            end
`endif
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized and directed bench for hazard_ctrl against an array-based pipeline model.
// Honours HAZARD_W_BYPASS_EN the same way the design does.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] grf_read_addr0;
    logic [4:0] grf_read_addr1;
    logic [1:0] grf_read_stage0;
    logic [1:0] grf_read_stage1;
    logic [4:0] grf_write_addr;
    logic [1:0] grf_write_stage;
    logic       ext_stall;
    logic       stall;
    logic [1:0] fwd_d0;
    logic [1:0] fwd_d1;
    logic [1:0] fwd_e0;
    logic [1:0] fwd_e1;
    logic [1:0] fwd_m1;

`ifdef HAZARD_W_BYPASS_EN
    localparam int W_CODE = 3;
`else
    localparam int W_CODE = 0;
`endif

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .grf_read_addr0 (grf_read_addr0),
        .grf_read_addr1 (grf_read_addr1),
        .grf_read_stage0(grf_read_stage0),
        .grf_read_stage1(grf_read_stage1),
        .grf_write_addr (grf_write_addr),
        .grf_write_stage(grf_write_stage),
        .ext_stall      (ext_stall),
        .stall          (stall),
        .fwd_d0         (fwd_d0),
        .fwd_d1         (fwd_d1),
        .fwd_e0         (fwd_e0),
        .fwd_e1         (fwd_e1),
        .fwd_m1         (fwd_m1)
    );

    // Model: index 1..3 = E, M, W; each entry is an in-flight instruction's register usage.
    int m_wa[4];
    int m_ws[4];
    int m_ra0[4];
    int m_ra1[4];

    int passCount  = 0;
    int checkCount = 0;
    int lastStall, lastFd0, lastFe0, lastFe1, lastFm1;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    endtask

    task automatic modelClear();
        for (int k = 0; k < 4; k++) begin
            m_wa[k] = 0; m_ws[k] = 0; m_ra0[k] = 0; m_ra1[k] = 0;
        end
    endtask

    function automatic int findProducer(input int p, input int r);
        if (r == 0) return 0;
        for (int k = p + 1; k <= 3; k++)
            if (m_wa[k] == r) return k;
        return 0;
    endfunction

    function automatic int modelFwd(input int p, input int r);
        int k;
        k = findProducer(p, r);
        if (k == 0 || k <= m_ws[k]) return 0;
        if (k == 3) return W_CODE;
        return k;
    endfunction

    function automatic int modelOperandStall(input int r, input int tuse);
        int k;
        if (r == 0 || tuse == 3) return 0;
        k = findProducer(0, r);
        if (k == 0) return 0;
        return (k + tuse <= m_ws[k]) ? 1 : 0;
    endfunction

    function automatic int modelFm1();
        if (m_ra1[2] != 0 && m_wa[3] == m_ra1[2]) return W_CODE;
        return 0;
    endfunction

    task automatic driveInputs(input int wa, input int ws, input int ra0, input int rs0,
                               input int ra1, input int rs1, input int ext);
        grf_write_addr  = wa[4:0];
        grf_write_stage = ws[1:0];
        grf_read_addr0  = ra0[4:0];
        grf_read_stage0 = rs0[1:0];
        grf_read_addr1  = ra1[4:0];
        grf_read_stage1 = rs1[1:0];
        ext_stall       = ext[0];
    endtask

    // One decode cycle: drive, compare every output with the model, then advance the model at the edge.
    task automatic applyStimulus(input int wa, input int ws, input int ra0, input int rs0,
                                 input int ra1, input int rs1, input int ext, input string tag);
        int expStall;
        @(negedge clk);
        driveInputs(wa, ws, ra0, rs0, ra1, rs1, ext);
        #1;
        expStall = (modelOperandStall(ra0, rs0) | modelOperandStall(ra1, rs1) | ext) != 0 ? 1 : 0;
        checkOutput({tag, ".stall"},  int'(stall),  expStall);
        checkOutput({tag, ".fwd_d0"}, int'(fwd_d0), modelFwd(0, ra0));
        checkOutput({tag, ".fwd_d1"}, int'(fwd_d1), modelFwd(0, ra1));
        checkOutput({tag, ".fwd_e0"}, int'(fwd_e0), modelFwd(1, m_ra0[1]));
        checkOutput({tag, ".fwd_e1"}, int'(fwd_e1), modelFwd(1, m_ra1[1]));
        checkOutput({tag, ".fwd_m1"}, int'(fwd_m1), modelFm1());
        lastStall = int'(stall);
        lastFd0   = int'(fwd_d0);
        lastFe0   = int'(fwd_e0);
        lastFe1   = int'(fwd_e1);
        lastFm1   = int'(fwd_m1);
        @(posedge clk);
        for (int k = 3; k >= 2; k--) begin
            m_wa[k] = m_wa[k-1]; m_ws[k] = m_ws[k-1];
            m_ra0[k] = m_ra0[k-1]; m_ra1[k] = m_ra1[k-1];
        end
        if (expStall != 0) begin
            m_wa[1] = 0; m_ws[1] = 0; m_ra0[1] = 0; m_ra1[1] = 0;
        end else begin
            m_wa[1] = wa; m_ws[1] = ws; m_ra0[1] = ra0; m_ra1[1] = ra1;
        end
    endtask

    task automatic nop(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 3, 0, 3, 0, "nop");
    endtask

    initial begin
        modelClear();
        rst_n = 1'b0;
        driveInputs(1, 2, 1, 0, 1, 0, 1);
        #3;
        checkOutput("reset.stall_ext", int'(stall), 1);
        checkOutput("reset.fwd_d0", int'(fwd_d0), 0);
        ext_stall = 1'b0;
        #1;
        checkOutput("reset.stall", int'(stall), 0);
        checkOutput("reset.fwd_m1", int'(fwd_m1), 0);
        driveInputs(0, 0, 0, 3, 0, 3, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // lw $1 then beq $1,$0: two stall cycles, then W forward
        applyStimulus(1, 2, 7, 1, 0, 3, 0, "lw1");
        applyStimulus(0, 0, 1, 0, 0, 0, 0, "beq1a");
        checkOutput("lw_beq.stall1", lastStall, 1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, "beq1b");
        checkOutput("lw_beq.stall2", lastStall, 1);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, "beq1c");
        checkOutput("lw_beq.release", lastStall, 0);
        checkOutput("lw_beq.fwd_d0", lastFd0, W_CODE);
        nop(3);

        // addu $2 then addu $3,$2,$2
        applyStimulus(2, 1, 8, 1, 9, 1, 0, "addu2");
        applyStimulus(3, 1, 2, 1, 2, 1, 0, "addu3");
        checkOutput("alu_alu.stall", lastStall, 0);
        nop(1);
        checkOutput("alu_alu.fwd_e0", lastFe0, 2);
        checkOutput("alu_alu.fwd_e1", lastFe1, 2);
        nop(3);

        // jal then jr $31
        applyStimulus(31, 0, 0, 3, 0, 3, 0, "jal");
        applyStimulus(0, 0, 31, 0, 0, 3, 0, "jr");
        checkOutput("jal_jr.stall", lastStall, 0);
        checkOutput("jal_jr.fwd_d0", lastFd0, 1);
        nop(3);

        // lw $4 then sw $4,0($5)
        applyStimulus(4, 2, 7, 1, 0, 3, 0, "lw4");
        applyStimulus(0, 0, 5, 1, 4, 2, 0, "sw4");
        checkOutput("lw_sw.stall", lastStall, 0);
        nop(2);
        checkOutput("lw_sw.fwd_m1", lastFm1, W_CODE);
        nop(3);

        // $0 never hazards; ext_stall bubbles E
        applyStimulus(0, 1, 8, 1, 9, 1, 0, "addu0");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "beq00");
        checkOutput("zero.stall", lastStall, 0);
        checkOutput("zero.fwd_d0", lastFd0, 0);
        nop(3);
        applyStimulus(10, 0, 0, 3, 0, 3, 1, "ext");
        checkOutput("ext.stall", lastStall, 1);
        applyStimulus(0, 0, 10, 0, 0, 3, 0, "ext_after");
        checkOutput("ext.bubble_fwd_d0", lastFd0, 0);
        checkOutput("ext.bubble_stall", lastStall, 0);
        nop(3);

        // Two writers to $6; E copy (lw) must win, then reset mid-stall
        applyStimulus(6, 0, 0, 3, 0, 3, 0, "w6a");
        applyStimulus(6, 2, 7, 1, 0, 3, 0, "w6b");
        applyStimulus(0, 0, 6, 0, 0, 0, 0, "beq6");
        checkOutput("youngest.stall", lastStall, 1);
        checkOutput("youngest.fwd_d0", lastFd0, 0);
        @(negedge clk);
        #1;
        checkOutput("rst_mid.before", int'(stall), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid.stall", int'(stall), 0);
        checkOutput("rst_mid.fwd_d0", int'(fwd_d0), 0);
        modelClear();
        driveInputs(0, 0, 0, 3, 0, 3, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic over a small register pool to provoke frequent matches
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3),
                          ($urandom_range(0, 7) == 0) ? 1 : 0, "rand");
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller consuming the per-instruction register-usage metadata emitted by the decode stage: read addresses with the stage each operand is first needed (Tuse), and write address with the stage its result becomes valid (Tnew). It holds a three-slot scoreboard of in-flight instructions (E, M, W) and uses it to generate the decode stall and forwarding selects for operands consumed in D, E and M. It sits beside the five-stage datapath, fed from decode and driving datapath muxes and pipeline-register enables.

## Interface
Parameters: none. Stage codes are fixed: DECODE=0, EXECUTE=1, MEM=2, MAX=3 (operand unused).
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- grf_read_addr0 / grf_read_addr1  in  5  D-stage rs / rt address
- grf_read_stage0 / grf_read_stage1  in  2  Tuse of each D operand
- grf_write_addr  in  5  D-stage destination; 0 = no write
- grf_write_stage  in  2  Tnew, the stage after which the result is valid
- ext_stall  in  1  external freeze request, e.g. mult/div busy
- stall  out  1  freeze F/D registers; bubble into E
- fwd_d0 / fwd_d1  out  2  source select for D-stage operands
- fwd_e0 / fwd_e1  out  2  source select for E-stage operands
- fwd_m1  out  2  source select for the M-stage rt (store data)

Forward codes: 0 = GRF read, 1 = D/E register (E slot), 2 = E/M register (M slot), 3 = M/W register (W slot).

## Operation
- Slot contents: write_addr, write_stage, read_addr0/1, read_stage0/1. Position index: D=0, E=1, M=2, W=3.
- Bubble: all addresses 0, read stages MAX, write_stage 0.
- Per rising edge: W<=M, M<=E. E<=D metadata if !stall, else bubble.
- Matching producer for a consumer at position p reading r: the youngest slot k>p with write_addr==r and r!=0. Older matches are ignored.
- A producer at k has its value when k > write_stage.
- Stall: a D operand with r!=0 and Tuse!=MAX stalls when its matching producer satisfies k+Tuse <= write_stage. stall = any D operand stall OR ext_stall.
- fwd_d*: code k if a matching producer exists and k > write_stage, else 0.
- fwd_e*: the same rule using the E slot's read addresses, with producers searched in M and W only.
- fwd_m1: 3 if W matches the M slot's read_addr1, else 0.
- Register $0 never stalls and never forwards.
- Outputs are combinational from the slots and D inputs.
- ext_stall inserts a bubble exactly as a hazard stall does.

## Timing
- Reset (rst_n low) clears all slots to bubble asynchronously. In reset: stall=ext_stall, all fwd_*=0. Reset asserted mid-stall drops the hazard stall immediately.
- Latency: stall and forward selects are valid in the same cycle as the D inputs; no registered outputs.
- Load-use against a D-stage branch reader: 2 stall cycles. Against an E-stage reader: 1 stall cycle. Against an M-stage store-data reader: 0 stall cycles.
- Back-to-back stalls re-evaluate every cycle against the advanced slots; the D inputs are held by the datapath.

## Configuration
- HAZARD_W_BYPASS_EN defined: the W slot is a forwarding source (code 3) for fwd_d*, fwd_e* and fwd_m1.
- HAZARD_W_BYPASS_EN undefined: code 3 is never produced, and W matches yield 0. The GRF must then provide write-through bypass.
- Stall behaviour is identical in both builds.

## Test plan
- lw $1 then beq $1,$0: stall=1 for 2 cycles, then stall=0 and fwd_d0=3.
- addu $2 then addu $3,$2,$2: no stall. On the next cycle, with the consumer in E, fwd_e0=fwd_e1=2.
- jal then jr $31: no stall; fwd_d0=1.
- lw $4 then sw $4,0($5): no stall. Two cycles later fwd_m1=3 (0 with HAZARD_W_BYPASS_EN undefined).
- addu $0 then beq $0,$0; and separately ext_stall=1 with no hazard: no hazard stall, fwd_d*=0. In the ext_stall case, stall=1 and E receives a bubble.
- Two writers to $6 in E and M, with beq $6 in D: the E producer is selected (stall if its Tnew >= 1). Pulse rst_n low mid-stall: stall drops in the same cycle.
